// File: rtl/leading_run_pkg.sv
// rtl/leading_run_pkg.sv - shared types and saturating-add helpers for the leading-run counter
// Purpose: run FSM state enum and saturating accumulator arithmetic.
// Ports:   none (package).
package leading_run_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } run_state_e;

    // Operands are carried at 32 bits and clamped to the cnt_w-bit maximum.
    // The sum is formed one bit wider so a carry out of cnt_w bits is never lost.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned cnt_w);
        logic [32:0] w_sum;
        logic [32:0] w_lim;
        w_sum = {1'b0, a} + {1'b0, b};
        w_lim = (33'd1 << cnt_w) - 33'd1;
        return (w_sum > w_lim) ? w_lim[31:0] : w_sum[31:0];
    endfunction

    // True when the unclamped sum has reached the cnt_w-bit maximum, i.e. the
    // reported count can no longer be trusted as the exact run length.
    function automatic logic sat_hit(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input int unsigned cnt_w);
        logic [32:0] w_sum;
        logic [32:0] w_lim;
        w_sum = {1'b0, a} + {1'b0, b};
        w_lim = (33'd1 << cnt_w) - 33'd1;
        return (w_sum >= w_lim);
    endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// rtl/priority_encoder_n.sv - leading-run priority encoder for one WIDTH-bit slice
// Purpose: count leading bits (from the MSB) equal to leading_bit.
// Ports:   leading_bit - run polarity
//          slice       - input slice, bit WIDTH-1 first
//          count       - number of leading matching bits, WIDTH if all match
//          valid       - a terminating bit exists in the slice (count < WIDTH)
module priority_encoder_n #(
    parameter  int WIDTH = 16,
    localparam int OFF_W = $clog2(WIDTH + 1)
) (
    input  logic             leading_bit,
    input  logic [WIDTH-1:0] slice,
    output logic [OFF_W-1:0] count,
    output logic             valid
);

    logic w_stop;

    // Scan from the MSB; the first mismatching bit fixes the count.
    always_comb begin
        count  = OFF_W'(WIDTH);
        w_stop = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_stop && (slice[i] != leading_bit)) begin
                count  = OFF_W'(WIDTH - 1 - i);
                w_stop = 1'b1;
            end
        end
    end

    assign valid = (count != OFF_W'(WIDTH));

endmodule

// File: rtl/leading_run_counter.sv
// rtl/leading_run_counter.sv - streaming leading-run length counter across WIDTH-bit slices
// Purpose: accumulate the leading run of equal bits over MSB-first slices and
//          report total length, terminator offset and saturation/exhaustion.
// Ports:   clk, rst            - clock, synchronous active-high reset
//          leading_bit         - run polarity, taken on the first beat of a run
//          in_valid/in_ready   - input slice handshake (in_data, in_last)
//          out_valid/out_ready - result handshake
//          out_count           - saturating run length
//          out_offset          - run bits within the final slice (WIDTH if none)
//          out_saturated       - run length reached the count maximum
//          out_exhausted       - in_last seen without a terminator
module leading_run_counter
    import leading_run_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int CNT_W = 8,
    localparam int OFF_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             leading_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [OFF_W-1:0] out_offset,
    output logic             out_saturated,
    output logic             out_exhausted
);

    run_state_e       r_state, w_next_state;
    logic [CNT_W-1:0] r_acc, w_next_acc;
    logic             r_sat, w_next_sat;
    logic             r_pol, w_next_pol;
    logic [CNT_W-1:0] r_count, w_next_count;
    logic [OFF_W-1:0] r_offset, w_next_offset;
    logic             r_saturated, w_next_saturated;
    logic             r_exhausted, w_next_exhausted;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_pol;
    logic [CNT_W-1:0] w_base;
    logic             w_base_sat;
    logic [OFF_W-1:0] w_enc_cnt;
    logic             w_found;
    logic [CNT_W-1:0] w_sum;
    logic             w_hit;
    logic             w_run_sat;

    assign w_in_ready = !rst && (r_state != DONE);
    assign w_accept   = in_valid && w_in_ready;

    // The first beat of a run starts from a clean accumulator and the port
    // polarity; later beats continue from the registered run state.
    assign w_pol      = (r_state == IDLE) ? leading_bit : r_pol;
    assign w_base     = (r_state == IDLE) ? '0 : r_acc;
    assign w_base_sat = (r_state == IDLE) ? 1'b0 : r_sat;

    priority_encoder_n #(
        .WIDTH(WIDTH)
    ) u_enc (
        .leading_bit(w_pol),
        .slice      (in_data),
        .count      (w_enc_cnt),
        .valid      (w_found)
    );

    // w_enc_cnt is already WIDTH when the slice has no terminator, so the
    // same addend serves both the terminating and the continuing case.
    assign w_sum     = CNT_W'(sat_add(32'(w_base), 32'(w_enc_cnt), CNT_W));
    assign w_hit     = sat_hit(32'(w_base), 32'(w_enc_cnt), CNT_W);
    assign w_run_sat = w_base_sat | w_hit;

    always_comb begin
        w_next_state     = r_state;
        w_next_acc       = r_acc;
        w_next_sat       = r_sat;
        w_next_pol       = r_pol;
        w_next_count     = r_count;
        w_next_offset    = r_offset;
        w_next_saturated = r_saturated;
        w_next_exhausted = r_exhausted;
        case (r_state)
            IDLE, COUNT: begin
                if (w_accept) begin
                    w_next_pol = w_pol;
                    if (w_found || in_last) begin
                        w_next_count     = w_sum;
                        w_next_offset    = w_enc_cnt;
                        w_next_saturated = w_run_sat;
                        w_next_exhausted = !w_found;
                        w_next_state     = DONE;
                    end else begin
                        w_next_acc   = w_sum;
                        w_next_sat   = w_run_sat;
                        w_next_state = COUNT;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_acc   = '0;
                    w_next_sat   = 1'b0;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_pol       <= 1'b0;
            r_count     <= '0;
            r_offset    <= '0;
            r_saturated <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_acc       <= w_next_acc;
            r_sat       <= w_next_sat;
            r_pol       <= w_next_pol;
            r_count     <= w_next_count;
            r_offset    <= w_next_offset;
            r_saturated <= w_next_saturated;
            r_exhausted <= w_next_exhausted;
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = (r_state == DONE);
    assign out_count     = r_count;
    assign out_offset    = r_offset;
    assign out_saturated = r_saturated;
    assign out_exhausted = r_exhausted;

endmodule

// File: tb/tb_leading_run_counter.sv
// tb/tb_leading_run_counter.sv - self-checking bench for leading_run_counter
module tb_leading_run_counter;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int OFF_W = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             leading_bit;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic [OFF_W-1:0] out_offset;
    logic             out_saturated;
    logic             out_exhausted;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] g_data [16];
    bit               g_last [16];
    bit               g_lb   [16];

    leading_run_counter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .leading_bit  (leading_bit),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .out_offset   (out_offset),
        .out_saturated(out_saturated),
        .out_exhausted(out_exhausted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Present one beat and hold it until the edge that accepts it.
    task automatic drive_beat(input logic [WIDTH-1:0] d, input bit last, input bit lb);
        int waited = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = d;
        in_last     = last;
        leading_bit = lb;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    // Reference: flatten the run's slices into one bit stream and locate the
    // first bit differing from the polarity.
    task automatic model(input bit pol, input int n, output int cnt, output int off,
                         output bit sat, output bit exh);
        bit q[$];
        int len;
        for (int b = 0; b < n; b++)
            for (int i = WIDTH - 1; i >= 0; i--) q.push_back(g_data[b][i]);
        len = q.size();
        exh = 1'b1;
        for (int i = 0; i < q.size(); i++)
            if (exh && q[i] != pol) begin
                len = i;
                exh = 1'b0;
            end
        sat = (len >= MAXC);
        cnt = sat ? MAXC : len;
        off = len - WIDTH * (n - 1);
    endtask

    task automatic do_run(input string tag, input bit pol, input int n);
        int ec, eo;
        bit es, ee;
        model(pol, n, ec, eo, es, ee);
        for (int j = 0; j < n; j++)
            drive_beat(g_data[j], g_last[j], (j == 0) ? pol : g_lb[j]);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq({tag, "_latency"},   int'(out_valid), 1);
        check_eq({tag, "_count"},     int'(out_count), ec);
        check_eq({tag, "_offset"},    int'(out_offset), eo);
        check_eq({tag, "_saturated"}, int'(out_saturated), int'(es));
        check_eq({tag, "_exhausted"}, int'(out_exhausted), int'(ee));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_released"}, int'(in_ready), 1);
        check_eq({tag, "_valid_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit pol;
        logic [WIDTH-1:0] fill;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        leading_bit = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready",  int'(in_ready), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_count",     int'(out_count), 0);
        check_eq("rst_offset",    int'(out_offset), 0);
        check_eq("rst_sat",       int'(out_saturated), 0);
        check_eq("rst_exh",       int'(out_exhausted), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", int'(in_ready), 1);

        g_data[0] = 4'b0010; g_last[0] = 1'b0;
        do_run("single", 1'b0, 1);

        g_data[0] = 4'b1111; g_data[1] = 4'b1111; g_data[2] = 4'b1000;
        g_last[0] = 0; g_last[1] = 0; g_last[2] = 0;
        g_lb[1] = 1'b0; g_lb[2] = 1'b0;
        do_run("multi", 1'b1, 3);

        g_data[0] = 4'b0000; g_data[1] = 4'b0000;
        g_last[0] = 0; g_last[1] = 1;
        g_lb[1] = 1'b1;
        do_run("exhaust", 1'b0, 2);

        for (int j = 0; j < 5; j++) begin
            g_data[j] = 4'b0000; g_last[j] = 0; g_lb[j] = 1'b1;
        end
        g_data[5] = 4'b0001; g_last[5] = 0; g_lb[5] = 1'b1;
        do_run("saturate", 1'b0, 6);

        // Result held with a pending input beat: nothing may be consumed.
        drive_beat(4'b1100, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0001; in_last = 1'b1; leading_bit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("hold_valid",    int'(out_valid), 1);
            check_eq("hold_count",    int'(out_count), 2);
            check_eq("hold_offset",   int'(out_offset), 2);
            check_eq("hold_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("hold_release_in_ready", int'(in_ready), 1);
        check_eq("hold_release_valid",    int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check_eq("hold_next_valid",  int'(out_valid), 1);
        check_eq("hold_next_count",  int'(out_count), 3);
        check_eq("hold_next_offset", int'(out_offset), 3);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset mid-run discards the partial run.
        drive_beat(4'b0000, 1'b0, 1'b0);
        drive_beat(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready",  int'(in_ready), 0);
        check_eq("midrst_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midrst_no_result", int'(out_valid), 0);
        g_data[0] = 4'b0100; g_last[0] = 1'b1;
        do_run("after_rst", 1'b0, 1);

        for (int r = 0; r < 40; r++) begin
            pol  = 1'($urandom);
            n    = $urandom_range(1, 6);
            fill = pol ? 4'hF : 4'h0;
            for (int j = 0; j < n - 1; j++) begin
                g_data[j] = fill;
                g_last[j] = 1'b0;
                g_lb[j]   = 1'($urandom);
            end
            g_data[n-1] = 4'($urandom);
            g_last[n-1] = 1'($urandom);
            g_lb[n-1]   = 1'($urandom);
            if (g_data[n-1] == fill) g_last[n-1] = 1'b1;
            do_run($sformatf("rand%0d", r), pol, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/leading_run_counter.md
# leading_run_counter

Streaming, parametrised successor to the fixed 2/4-bit leading-run priority encoders in the decode path. Accepts WIDTH-bit slices MSB-first over a valid/ready handshake and accumulates the length of the leading run of bits equal to a per-run leading bit across any number of slices. Reports the total run length, the terminator position within the final slice, and saturation/exhaustion flags. Sits ahead of the unary/prefix field extraction in the decoder.

## Interface
- WIDTH, 16: slice width in bits; power of two, ≥2.
- CNT_W, 8: width of the run-length accumulator and out_count.
- OFF_W (derived, not overridable): $clog2(WIDTH+1).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- leading_bit  in  1  run polarity; sampled only on the first accepted beat of a run.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  slice; bit WIDTH-1 is the earliest bit in the stream.
- in_last  in  1  final slice of the stream.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_count  out  CNT_W  total run length, saturating.
- out_offset  out  OFF_W  run bits in the final slice (index of the terminator from the MSB); WIDTH if none.
- out_saturated  out  1  true run length ≥ 2^CNT_W−1.
- out_exhausted  out  1  in_last seen with no terminator.

## Operation
- FSM states: IDLE (no run open), COUNT (run open), DONE (result held).
- in_ready = !rst && state != DONE. out_valid = (state == DONE).
- Beat accepted when in_valid && in_ready.
- Polarity: IDLE beat uses the leading_bit port and registers it; COUNT beats use the registered value and ignore the port.
- Per beat: the encoder returns cnt (0..WIDTH), the number of leading in_data bits equal to the polarity, and found = (cnt < WIDTH).
- found: out_count = sat(acc + cnt), out_offset = cnt, out_exhausted = 0 → DONE.
- !found && in_last: out_count = sat(acc + WIDTH), out_offset = WIDTH, out_exhausted = 1 → DONE.
- !found && !in_last: acc = sat(acc + WIDTH) → COUNT.
- acc starts at 0 on each IDLE beat.
- Sums are computed at CNT_W+1 bits. Any sum > 2^CNT_W−1 clamps to 2^CNT_W−1 and sets a sticky sat flag for the run; out_saturated reflects it.
- DONE && out_ready → IDLE, acc and sat cleared. Outputs are held unchanged while out_ready is low.
- Data bits after the terminator in the final slice are discarded; the next run starts on the next beat.
- rst (any state, including mid-run) → IDLE, acc = 0, sat = 0, no result emitted.

## Timing
- Reset values: state IDLE, out_valid 0, out_count 0, out_offset 0, out_saturated 0, out_exhausted 0, in_ready 0 while rst is high and 1 in the first cycle after.
- Latency: terminating beat accepted in cycle N → out_valid high in N+1 with registered outputs.
- Result handshake in cycle M → in_ready high in M+1. One bubble cycle per run, so throughput is ≤ 1 run per 2 cycles for single-beat runs.
- Multi-beat run of k beats: out_valid at (cycle of beat k) + 1. No bubble between beats inside a run.
- in_valid during DONE is ignored; in_data must be held by the producer (standard valid/ready).

## Structure
- Shared package leading_run_pkg: the state enum (IDLE, COUNT, DONE) and a sat_add function parametrised by CNT_W.
- Sub-module priority_encoder_n: combinational, parameter WIDTH.
  - Inputs: leading_bit, slice[WIDTH-1:0].
  - Outputs: count[OFF_W-1:0], valid.
  - Generalises the fixed 2/4-bit encoders; must match them exactly at WIDTH 2 and 4.

## Test plan
- WIDTH=4, leading_bit=0, one beat 4'b0010 → out_valid next cycle, count=2, offset=2, exhausted=0, saturated=0.
- WIDTH=4, leading_bit=1, beats 1111, 1111, 1000 (port toggled after beat 1) → count=9, offset=1.
- WIDTH=4, leading_bit=0, beats 0000, 0000 with in_last on beat 2 → count=8, offset=4, exhausted=1.
- WIDTH=4, CNT_W=4, leading_bit=0, five beats 0000 then 0001 → count=15, saturated=1, offset=3.
- out_ready held low 3 cycles in DONE with in_valid=1 → outputs stable, in_ready=0, no beat consumed; in_ready=1 the cycle after handshake.
- rst pulsed after 2 beats of a run → no result; next run 4'b0100 (leading_bit=0) → count=1.
